// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control unit for the multicycle RV64 datapath. Handshakes with instruction
// and data memories through req/ready so memories may take any number of
// cycles. A per-state wait counter converts a stalled request into a bus error.
//
// Optional build macro:
//   ILLEGAL_TRAP_EN  - illegal decodes enter a one-cycle TRAP state that loads
//                      the trap vector into PC. When undefined, an illegal
//                      instruction simply retires as a NOP and trap stays 0.
//
// Parameters:
//   TIMEOUT     maximum request cycles without ready before bus error (>=1)
//
// Ports:
//   CLK, RST                 clock / synchronous active-high reset
//   opcode, funct3, funct7_5 instruction fields from the instruction register
//   zero                     ALU zero flag (branch resolution)
//   imem_ready, dmem_ready   memory completion strobes
//   imem_req, dmem_req       memory requests; dmem_we marks a data write
//   ir_we, pc_we, ab_we,
//   alu_out_we, mdr_we,
//   rf_we                    datapath register enables (ab_we loads A and B)
//   alu_a_sel                0=A, 1=PC, 2=old PC
//   alu_b_sel                0=B, 1=4, 2=imm, 3=imm<<1
//   alu_op                   000 add, 001 sub, 010 and, 011 or, 100 xor
//   pc_src                   0=ALU, 1=ALU_OUT, 2=trap vector
//   wb_sel                   0=ALU_OUT, 1=MDR
//   bus_err, trap, halted    status
//   state                    current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       ab_we,
  output logic       alu_out_we,
  output logic       mdr_we,
  output logic       rf_we,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       wb_sel,
  output logic       bus_err,
  output logic       trap,
  output logic       halted,
  output logic [3:0] state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_ALU   = 4'd8,
    WB_LD    = 4'd9,
    BRANCH   = 4'd10,
    TRAP     = 4'd11,
    HALT     = 4'd12,
    ERR      = 4'd13
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_TARGET = TRAP;
`else
  localparam state_t ILLEGAL_TARGET = FETCH;
`endif

  state_t        state_reg, state_next, dispatch;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
  logic          timeout_hit, waiting;
  logic          r_legal, i_legal, b_legal;
  logic [2:0]    r_op;

  // Decode legality and R-type ALU function; the IR is stable for the whole
  // instruction so these can be used in DECODE and in EXEC_R alike.
  assign r_legal = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                   (funct3 == 3'b110) || (funct3 == 3'b100);
  assign i_legal = (funct3 == 3'b000);
  assign b_legal = (funct3[2:1] == 2'b00);

  always_comb begin
    r_op = ALU_ADD;
    case (funct3)
      3'b000:  r_op = funct7_5 ? ALU_SUB : ALU_ADD;
      3'b111:  r_op = ALU_AND;
      3'b110:  r_op = ALU_OR;
      3'b100:  r_op = ALU_XOR;
      default: r_op = ALU_ADD;
    endcase
  end

  always_comb begin
    dispatch = ILLEGAL_TARGET;
    case (opcode)
      OP_R:      if (r_legal) dispatch = EXEC_R;
      OP_I:      if (i_legal) dispatch = EXEC_I;
      OP_LOAD,
      OP_STORE:  dispatch = MEM_ADDR;
      OP_BRANCH: if (b_legal) dispatch = BRANCH;
      OP_SYSTEM: dispatch = HALT;
      default:   dispatch = ILLEGAL_TARGET;
    endcase
  end

  // The cycle that would bring the counter to TIMEOUT without ready is the
  // last one tolerated; ready in that same cycle still wins in the FSM below.
  assign cnt_inc     = cnt_reg + 1'b1;
  assign timeout_hit = (cnt_inc == CW'(TIMEOUT));
  assign waiting     = ((state_reg == FETCH)  && !imem_ready) ||
                       ((state_reg == MEM_RD) && !dmem_ready) ||
                       ((state_reg == MEM_WR) && !dmem_ready);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg) cnt_next = '0;
    else if (waiting)            cnt_next = cnt_inc;
  end

  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    ab_we      = 1'b0;
    alu_out_we = 1'b0;
    mdr_we     = 1'b0;
    rf_we      = 1'b0;
    alu_a_sel  = 2'd0;
    alu_b_sel  = 2'd0;
    alu_op     = ALU_ADD;
    pc_src     = 2'd0;
    wb_sel     = 1'b0;
    bus_err    = 1'b0;
    trap       = 1'b0;
    halted     = 1'b0;

    case (state_reg)
      IDLE: state_next = FETCH;

      FETCH: begin
        imem_req  = 1'b1;
        alu_a_sel = 2'd1;
        alu_b_sel = 2'd1;
        alu_op    = ALU_ADD;
        if (imem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          pc_src     = 2'd0;
          state_next = DECODE;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end

      DECODE: begin
        // Speculatively compute the branch target while A/B load.
        ab_we      = 1'b1;
        alu_a_sel  = 2'd2;
        alu_b_sel  = 2'd3;
        alu_op     = ALU_ADD;
        alu_out_we = 1'b1;
        state_next = dispatch;
      end

      EXEC_R: begin
        alu_a_sel  = 2'd0;
        alu_b_sel  = 2'd0;
        alu_op     = r_op;
        alu_out_we = 1'b1;
        state_next = WB_ALU;
      end

      EXEC_I: begin
        alu_a_sel  = 2'd0;
        alu_b_sel  = 2'd2;
        alu_op     = ALU_ADD;
        alu_out_we = 1'b1;
        state_next = WB_ALU;
      end

      WB_ALU: begin
        rf_we      = 1'b1;
        wb_sel     = 1'b0;
        state_next = FETCH;
      end

      MEM_ADDR: begin
        alu_a_sel  = 2'd0;
        alu_b_sel  = 2'd2;
        alu_op     = ALU_ADD;
        alu_out_we = 1'b1;
        state_next = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      end

      MEM_RD: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          mdr_we     = 1'b1;
          state_next = WB_LD;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end

      WB_LD: begin
        rf_we      = 1'b1;
        wb_sel     = 1'b1;
        state_next = FETCH;
      end

      MEM_WR: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
        if (dmem_ready)       state_next = FETCH;
        else if (timeout_hit) state_next = ERR;
      end

      BRANCH: begin
        // beq/bne: funct3[0] inverts the sense of the zero flag.
        alu_a_sel = 2'd0;
        alu_b_sel = 2'd0;
        alu_op    = ALU_SUB;
        if (zero ^ funct3[0]) begin
          pc_we  = 1'b1;
          pc_src = 2'd1;
        end
        state_next = FETCH;
      end

      TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        pc_we  = 1'b1;
        pc_src = 2'd2;
        trap   = 1'b1;
`endif
        state_next = FETCH;
      end

      HALT: halted = 1'b1;

      ERR: bus_err = 1'b1;

      default: state_next = IDLE;
    endcase

    // Reset silences the datapath immediately, before the registered reset
    // takes effect on the next edge.
    if (RST) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      ab_we      = 1'b0;
      alu_out_we = 1'b0;
      mdr_we     = 1'b0;
      rf_we      = 1'b0;
      alu_a_sel  = 2'd0;
      alu_b_sel  = 2'd0;
      alu_op     = ALU_ADD;
      pc_src     = 2'd0;
      wb_sel     = 1'b0;
      bus_err    = 1'b0;
      trap       = 1'b0;
      halted     = 1'b0;
    end
  end

  assign state = RST ? 4'd0 : state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed plus randomised instruction sequences for multicycle_ctrl with
// TIMEOUT=4. Reactive memory responders answer requests after a chosen number
// of wait cycles and toggle stray ready strobes when nothing is requested.
// A per-instruction reference model derives cycle counts, enable counts and
// strobe positions from the instruction class and the wait-cycle counts.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int TO = 4;

`ifdef ILLEGAL_TRAP_EN
  localparam int TRAP_EN = 1;
`else
  localparam int TRAP_EN = 0;
`endif

  logic       CLK, RST;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, zero, imem_ready, dmem_ready;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, ab_we, alu_out_we;
  logic       mdr_we, rf_we, wb_sel, bus_err, trap, halted;
  logic [1:0] alu_a_sel, alu_b_sel, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [25:0] outs;

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .ab_we(ab_we), .alu_out_we(alu_out_we), .mdr_we(mdr_we),
    .rf_we(rf_we), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .pc_src(pc_src), .wb_sel(wb_sel), .bus_err(bus_err), .trap(trap),
    .halted(halted), .state(state)
  );

  assign outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, ab_we, alu_out_we,
                 mdr_we, rf_we, alu_a_sel, alu_b_sel, alu_op, pc_src, wb_sel,
                 bus_err, trap, halted, state};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  int n_vec = 0, n_err = 0, n_instr = 0;
  bit rst_req;

  // Pending instruction, applied on the first cycle of its fetch.
  logic [6:0] p_op;
  logic [2:0] p_f3;
  logic       p_f75, p_zero;
  int         p_iw, p_dw;
  int         i_wait, d_wait, i_cnt, d_cnt;
  logic       last_imem, prev_imem;

  // Observed per-instruction tallies.
  int c_imem, c_ir, c_pc0, c_pc1, c_pc2, c_dreq, c_dwe, c_mdr, c_rf, c_rfld;
  int c_aow, c_trap, c_bad, c_sub, c_ab, exec_op, idx_mdr, idx_rf;
  // Expected per-instruction values from the model.
  int e_cyc, e_rf, e_rfld, e_rf_idx, e_mdr, e_mdr_idx, e_dreq, e_dwe;
  int e_pc1, e_pc2, e_trap, e_aow, e_op, e_sub;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit first);
    @(posedge CLK);
    #1;
    RST = rst_req;
    if (first) begin
      opcode = p_op; funct3 = p_f3; funct7_5 = p_f75; zero = p_zero;
      i_wait = p_iw; d_wait = p_dw;
    end
    #1;
    if (imem_req) begin imem_ready = (i_cnt >= i_wait); i_cnt++; end
    else begin imem_ready = 1'($urandom_range(0, 1)); i_cnt = 0; end
    if (dmem_req) begin dmem_ready = (d_cnt >= d_wait); d_cnt++; end
    else begin dmem_ready = 1'($urandom_range(0, 1)); d_cnt = 0; end
    #2;
    prev_imem = last_imem;
    last_imem = imem_req;
  endtask

  task automatic acc(input int j);
    if (imem_req) c_imem++;
    if (ir_we) c_ir++;
    if (pc_we) begin
      if (pc_src == 2'd0) c_pc0++;
      if (pc_src == 2'd1) c_pc1++;
      if (pc_src == 2'd2) c_pc2++;
    end
    if (dmem_req) c_dreq++;
    if (dmem_we) c_dwe++;
    if (mdr_we) begin c_mdr++; idx_mdr = j; end
    if (rf_we) begin c_rf++; idx_rf = j; if (wb_sel) c_rfld++; end
    if (alu_out_we) c_aow++;
    if (alu_out_we && alu_a_sel == 2'd0) exec_op = int'(alu_op);
    if (alu_op == 3'b001) c_sub++;
    if (ab_we) c_ab++;
    if (trap) c_trap++;
    if (bus_err || halted) c_bad++;
  endtask

  // Reference model: instruction class -> expected timeline summary.
  task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                       input logic z, input int iw, input int dw);
    int kind; // 0 R, 1 I, 2 LD, 3 SD, 4 BR, 5 HALT, 6 illegal
    case (op)
      7'b0110011: kind = (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd4) ? 0 : 6;
      7'b0010011: kind = (f3 == 3'd0) ? 1 : 6;
      7'b0000011: kind = 2;
      7'b0100011: kind = 3;
      7'b1100011: kind = (f3 == 3'd0 || f3 == 3'd1) ? 4 : 6;
      7'b1110011: kind = 5;
      default:    kind = 6;
    endcase
    e_rf = 0; e_rfld = 0; e_rf_idx = -1; e_mdr = 0; e_mdr_idx = -1;
    e_dreq = 0; e_dwe = 0; e_pc1 = 0; e_pc2 = 0; e_trap = 0; e_aow = 1;
    e_op = 7; e_sub = 0; e_cyc = iw + 2;
    case (kind)
      0, 1: begin
        e_cyc = iw + 4; e_aow = 2; e_rf = 1; e_rf_idx = iw + 3; e_op = 0;
        if (kind == 0) begin
          if (f3 == 3'd0) begin e_op = f75 ? 1 : 0; e_sub = f75 ? 1 : 0; end
          if (f3 == 3'd7) e_op = 2;
          if (f3 == 3'd6) e_op = 3;
          if (f3 == 3'd4) e_op = 4;
        end
      end
      2: begin
        e_cyc = iw + 5 + dw; e_aow = 2; e_op = 0; e_dreq = dw + 1;
        e_mdr = 1; e_mdr_idx = iw + 3 + dw;
        e_rf = 1; e_rfld = 1; e_rf_idx = iw + 4 + dw;
      end
      3: begin
        e_cyc = iw + 4 + dw; e_aow = 2; e_op = 0; e_dreq = dw + 1; e_dwe = dw + 1;
      end
      4: begin
        e_cyc = iw + 3; e_sub = 1; e_pc1 = int'(z ^ f3[0]);
      end
      5: e_cyc = iw + 2;
      default: begin
        e_cyc = iw + 2 + TRAP_EN; e_pc2 = TRAP_EN; e_trap = TRAP_EN;
      end
    endcase
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic z, input int iw, input int dw);
    string t;
    model(op, f3, f75, z, iw, dw);
    p_op = op; p_f3 = f3; p_f75 = f75; p_zero = z; p_iw = iw; p_dw = dw;
    c_imem = 0; c_ir = 0; c_pc0 = 0; c_pc1 = 0; c_pc2 = 0; c_dreq = 0; c_dwe = 0;
    c_mdr = 0; c_rf = 0; c_rfld = 0; c_aow = 0; c_trap = 0; c_bad = 0; c_sub = 0;
    c_ab = 0; exec_op = 7; idx_mdr = -1; idx_rf = -1;
    n_instr++;
    t = $sformatf("#%0d", n_instr);
    for (int j = 0; j < e_cyc; j++) begin
      tick(j == 0);
      if (j == 0) chk({t, " fetch_start"}, int'(imem_req && !prev_imem), 1);
      acc(j);
    end
    chk({t, " imem_req_cycles"}, c_imem, iw + 1);
    chk({t, " ir_we"}, c_ir, 1);
    chk({t, " pc_we_alu"}, c_pc0, 1);
    chk({t, " pc_we_branch"}, c_pc1, e_pc1);
    chk({t, " pc_we_trap"}, c_pc2, e_pc2);
    chk({t, " trap"}, c_trap, e_trap);
    chk({t, " ab_we"}, c_ab, 1);
    chk({t, " alu_out_we"}, c_aow, e_aow);
    chk({t, " exec_alu_op"}, exec_op, e_op);
    chk({t, " sub_cycles"}, c_sub, e_sub);
    chk({t, " dmem_req_cycles"}, c_dreq, e_dreq);
    chk({t, " dmem_we_cycles"}, c_dwe, e_dwe);
    chk({t, " mdr_we"}, c_mdr, e_mdr);
    chk({t, " mdr_we_idx"}, idx_mdr, e_mdr_idx);
    chk({t, " rf_we"}, c_rf, e_rf);
    chk({t, " rf_we_idx"}, idx_rf, e_rf_idx);
    chk({t, " rf_we_mdr"}, c_rfld, e_rfld);
    chk({t, " status"}, c_bad, 0);
    $display("instr %0d: op=%b f3=%b f75=%b zero=%b iw=%0d dw=%0d cycles=%0d",
             n_instr, op, f3, f75, z, iw, dw, e_cyc);
  endtask

  initial begin
    logic [6:0] rop;
    int cnt;
    rst_req = 1'b1; RST = 1'b1;
    opcode = 7'b0110011; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    i_wait = 0; d_wait = 0; i_cnt = 0; d_cnt = 0; last_imem = 1'b0; prev_imem = 1'b0;

    // Reset: outputs silent regardless of ready strobes.
    for (int k = 0; k < 3; k++) begin
      tick(1'b0);
      chk($sformatf("reset_outputs_%0d", k), int'(outs), 0);
    end

    // add after reset: IDLE, FETCH, DECODE, EXEC_R, WB_ALU, next FETCH at cycle 6.
    rst_req = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      tick(1'b0);
      if (rf_we) cnt++;
      case (k)
        1: chk("add_c1_idle", int'(state), 0);
        2: chk("add_c2_fetch", int'(state), 1);
        3: chk("add_c3_decode", int'(state), 2);
        4: chk("add_c4_exec_r", int'(state), 3);
        default: chk("add_c5_wb_alu", int'(state), 8);
      endcase
      if (k == 2) chk("add_first_imem_req", int'(imem_req), 1);
    end
    chk("add_rf_we_once", cnt, 1);
    $display("directed add after reset done");

    run_instr(7'b0000011, 3'd3, 1'b0, 1'b0, 0, 3);   // ld, 3 data wait cycles
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0);   // beq taken
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b1, 0, 0);   // bne not taken
    run_instr(7'b0000000, 3'd0, 1'b0, 1'b0, 1, 0);   // illegal opcode
    run_instr(7'b0100011, 3'd3, 1'b0, 1'b0, 3, 3);   // sd, maximum tolerated waits

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0: rop = 7'b0110011;
        1: rop = 7'b0010011;
        2: rop = 7'b0000011;
        3: rop = 7'b0100011;
        4: rop = 7'b1100011;
        5: rop = 7'b0000000;
        default: rop = 7'b1101111;
      endcase
      run_instr(rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, TO - 1),
                $urandom_range(0, TO - 1));
    end

    // Instruction memory never answers: ERR after TIMEOUT wait cycles.
    p_op = 7'b0110011; p_f3 = 3'd0; p_f75 = 1'b0; p_zero = 1'b0; p_iw = 100; p_dw = 0;
    for (int k = 0; k < TO; k++) begin
      tick(k == 0);
      chk($sformatf("timeout_fetch_%0d", k), int'(state), 1);
    end
    tick(1'b0);
    chk("timeout_err_state", int'(state), 13);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0);
      if (bus_err) cnt++;
    end
    chk("bus_err_held", cnt, 4);
    $display("fetch timeout -> bus error checked");

    rst_req = 1'b1;
    tick(1'b0);
    chk("err_reset_outputs", int'(outs), 0);
    rst_req = 1'b0;
    tick(1'b0);
    chk("err_reset_idle", int'(state), 0);
    chk("err_reset_bus_err", int'(bus_err), 0);

    // Ready on the last tolerated wait cycle is accepted.
    run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, TO - 1, 0);

    // Reset during a stalled store.
    p_op = 7'b0100011; p_f3 = 3'd3; p_f75 = 1'b0; p_zero = 1'b0; p_iw = 0; p_dw = 100;
    for (int k = 0; k < 4; k++) tick(k == 0);
    chk("sd_in_mem_wr", int'(state), 7);
    chk("sd_dmem_req", int'(dmem_req), 1);
    chk("sd_dmem_we", int'(dmem_we), 1);
    rst_req = 1'b1;
    tick(1'b0);
    chk("rst_drops_dmem_req", int'(dmem_req), 0);
    chk("rst_drops_dmem_we", int'(dmem_we), 0);
    rst_req = 1'b0;
    tick(1'b0);
    chk("rst_mid_wr_idle", int'(state), 0);
    $display("reset during store wait checked");

    // ebreak: halted until the next reset.
    run_instr(7'b1110011, 3'd0, 1'b0, 1'b0, $urandom_range(0, TO - 1), 0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1'b0);
      if (halted && !imem_req) cnt++;
    end
    chk("halted_held", cnt, 6);
    chk("halt_state", int'(state), 12);
    rst_req = 1'b1;
    tick(1'b0);
    chk("halt_reset_halted", int'(halted), 0);
    rst_req = 1'b0;
    tick(1'b0);
    chk("halt_reset_idle", int'(state), 0);
    tick(1'b0);
    chk("halt_reset_fetch", int'(imem_req), 1);
    $display("ebreak halt and reset checked");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
